// File: rtl/fetch_step_sequencer.sv
// Fetch/execute timing sequencer for the mini 8-bit CPU: it drives the program
// counter enable and sequences T0/T1/T2 followed by EXEC_CYCLES execute slots.
module fetch_step_sequencer #(
  parameter int EXEC_CYCLES = 3,    // legal range 1..7
  parameter bit WRAP_STOP   = 1'b1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Halt,
  input  logic [3:0] Counter_Out,
  input  logic       blow_up,
  output logic       Counter_En,
  output logic       Mar_Load,
  output logic       Ir_Load,
  output logic       Exec_En,
  output logic [2:0] Exec_Step,
  output logic       Busy,
  output logic       Halted,
  output logic       Wrapped,
  output logic [3:0] Fetch_Addr,
  output logic [7:0] Instr_Count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_EXEC
  } state_t;

  localparam logic [2:0] LAST_STEP = 3'(EXEC_CYCLES - 1);

  state_t     state;
  state_t     next_state;
  logic [2:0] step;
  logic       stop_pending;
  logic       last_slot;

  assign last_slot = (state == S_EXEC) && (step == LAST_STEP);

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // NOTE: each combinational output gets a default first so no latch can be inferred.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (Run) next_state = S_T0;
      S_T0:   next_state = S_T1;
      S_T1:   next_state = S_T2;
      S_T2:   next_state = S_EXEC;
      S_EXEC: begin
        if (last_slot) begin
          if (Halt || (WRAP_STOP && stop_pending)) next_state = S_IDLE;
          else                                     next_state = S_T0;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Strobes decode only from the registered state, so an async reset kills them at once.
  always_comb begin
    Counter_En = 1'b0;
    Mar_Load   = 1'b0;
    Ir_Load    = 1'b0;
    Exec_En    = 1'b0;
    Exec_Step  = 3'd0;
    Busy       = (state != S_IDLE);
    case (state)
      S_T0:   Mar_Load   = 1'b1;
      S_T1:   Counter_En = 1'b1;
      S_T2:   Ir_Load    = 1'b1;
      S_EXEC: begin
        Exec_En   = 1'b1;
        Exec_Step = step;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      step         <= 3'd0;
      Fetch_Addr   <= 4'd0;
      Instr_Count  <= 8'd0;
      Halted       <= 1'b0;
      Wrapped      <= 1'b0;
      stop_pending <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Run) begin
            Halted       <= 1'b0;
            Wrapped      <= 1'b0;
            Instr_Count  <= 8'd0;
            stop_pending <= 1'b0;
          end
        end
        S_T0: Fetch_Addr <= Counter_Out;
        S_T2: begin
          if (blow_up) begin
            Wrapped      <= 1'b1;
            stop_pending <= 1'b1;
          end
        end
        S_EXEC: begin
          if (last_slot) begin
            step         <= 3'd0;
            stop_pending <= 1'b0;
            if (Instr_Count != 8'hFF) Instr_Count <= Instr_Count + 8'd1;
            if (Halt) Halted <= 1'b1;
          end else begin
            step <= step + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_step_sequencer.sv
// Bench for fetch_step_sequencer: two instances (WRAP_STOP=1 and 0) each closed
// around a 4-bit counter model, compared cycle by cycle with a position-based model.
module tb_fetch_step_sequencer;

  localparam int E      = 3;
  localparam int PERIOD = 3 + E;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic Run   = 1'b0;
  logic Halt  = 1'b0;

  always #5 Clock = ~Clock;

  // index 0: WRAP_STOP=1, index 1: WRAP_STOP=0
  logic [3:0] cnt [2];
  logic       blow[2];
  logic       ce[2], mar[2], ir[2], ex[2], busy[2], hlt[2], wrp[2];
  logic [2:0] stp[2];
  logic [3:0] fa[2];
  logic [7:0] ic[2];
  logic [21:0] dv[2];
  logic [21:0] ev[2];

  int errors = 0;
  int checks = 0;

  bit         m_run [2];
  bit         m_halt[2];
  bit         m_wrap[2];
  bit         m_pend[2];
  int         m_pos [2];
  int         m_ic  [2];
  logic [3:0] m_fa  [2];

  fetch_step_sequencer #(.EXEC_CYCLES(E), .WRAP_STOP(1'b1)) dut (
    .Clock(Clock), .Reset(Reset), .Run(Run), .Halt(Halt),
    .Counter_Out(cnt[0]), .blow_up(blow[0]),
    .Counter_En(ce[0]), .Mar_Load(mar[0]), .Ir_Load(ir[0]), .Exec_En(ex[0]),
    .Exec_Step(stp[0]), .Busy(busy[0]), .Halted(hlt[0]), .Wrapped(wrp[0]),
    .Fetch_Addr(fa[0]), .Instr_Count(ic[0])
  );

  fetch_step_sequencer #(.EXEC_CYCLES(E), .WRAP_STOP(1'b0)) dut_nw (
    .Clock(Clock), .Reset(Reset), .Run(Run), .Halt(Halt),
    .Counter_Out(cnt[1]), .blow_up(blow[1]),
    .Counter_En(ce[1]), .Mar_Load(mar[1]), .Ir_Load(ir[1]), .Exec_En(ex[1]),
    .Exec_Step(stp[1]), .Busy(busy[1]), .Halted(hlt[1]), .Wrapped(wrp[1]),
    .Fetch_Addr(fa[1]), .Instr_Count(ic[1])
  );

  // Program counter environment: advances on En, blow_up marks the 15->0 step.
  always @(posedge Clock or posedge Reset) begin
    for (int i = 0; i < 2; i++) begin
      if (Reset) begin
        cnt[i]  <= 4'd0;
        blow[i] <= 1'b0;
      end else if (ce[i]) begin
        cnt[i]  <= cnt[i] + 4'd1;
        blow[i] <= (cnt[i] == 4'hF);
      end
    end
  end

  // Reference: an instruction is a position 0..PERIOD-1 inside a running burst.
  always @(posedge Clock or posedge Reset) begin
    for (int i = 0; i < 2; i++) begin
      if (Reset) begin
        m_run[i] <= 1'b0; m_pos[i] <= 0; m_halt[i] <= 1'b0; m_wrap[i] <= 1'b0;
        m_pend[i] <= 1'b0; m_ic[i] <= 0; m_fa[i] <= 4'd0;
      end else if (!m_run[i]) begin
        if (Run) begin
          m_run[i] <= 1'b1; m_pos[i] <= 0; m_halt[i] <= 1'b0; m_wrap[i] <= 1'b0;
          m_pend[i] <= 1'b0; m_ic[i] <= 0;
        end
      end else begin
        if (m_pos[i] == 0) m_fa[i] <= cnt[i];
        if (m_pos[i] == 2 && blow[i]) begin
          m_wrap[i] <= 1'b1;
          m_pend[i] <= 1'b1;
        end
        if (m_pos[i] == PERIOD - 1) begin
          m_ic[i]   <= (m_ic[i] < 255) ? m_ic[i] + 1 : 255;
          m_pend[i] <= 1'b0;
          m_pos[i]  <= 0;
          if (Halt) begin
            m_halt[i] <= 1'b1;
            m_run[i]  <= 1'b0;
          end else if (i == 0 && m_pend[i]) begin
            m_run[i]  <= 1'b0;
          end
        end else begin
          m_pos[i] <= m_pos[i] + 1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      dv[i] = {ce[i], mar[i], ir[i], ex[i], stp[i], busy[i], hlt[i], wrp[i], fa[i], ic[i]};
      ev[i] = {(m_run[i] && m_pos[i] == 1), (m_run[i] && m_pos[i] == 0),
               (m_run[i] && m_pos[i] == 2), (m_run[i] && m_pos[i] >= 3),
               (m_run[i] && m_pos[i] >= 3) ? 3'(m_pos[i] - 3) : 3'd0,
               m_run[i], m_halt[i], m_wrap[i], m_fa[i], 8'(m_ic[i])};
    end
  end

  task automatic tick();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic do_reset();
    Run = 1'b0; Halt = 1'b0; Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (dv[i] !== 22'd0) begin
        errors++;
        $display("FAIL reset_outputs[%0d] got=%h want=0", i, dv[i]);
      end
    end
    tick();
    Reset = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (dv[i] !== 22'd0) begin
        errors++;
        $display("FAIL reset_idle[%0d] got=%h want=0", i, dv[i]);
      end
    end
  endtask

  task automatic test_run_and_wrap();
    int en_count;
    en_count = 0;
    do_reset();
    Run = 1'b1;
    tick();
    Run = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (dv[i] !== ev[i]) begin
          errors++;
          $display("FAIL wrap_cycle[%0d] c=%0d got=%h want=%h", i, c, dv[i], ev[i]);
        end
      end
      if (c <= 18 && ce[0] === 1'b1) en_count++;
      if (c == 2 || c == 8 || c == 14) begin
        checks++;
        if (ce[0] !== 1'b1 || fa[0] !== 4'((c - 2) / 6)) begin
          errors++;
          $display("FAIL counter_en_slot c=%0d en=%b addr=%0d want en=1 addr=%0d",
                   c, ce[0], fa[0], (c - 2) / 6);
        end
      end
      if (c == 13) begin
        checks++;
        if (ic[0] !== 8'd2) begin
          errors++;
          $display("FAIL instr_count_c13 got=%0d want=2", ic[0]);
        end
      end
      if (c == 97) begin
        checks++;
        if (busy[0] !== 1'b0 || wrp[0] !== 1'b1 || ic[0] !== 8'd16 || fa[0] !== 4'd15) begin
          errors++;
          $display("FAIL wrap_stop busy=%b wrapped=%b count=%0d addr=%0d want 0 1 16 15",
                   busy[0], wrp[0], ic[0], fa[0]);
        end
        checks++;
        if (busy[1] !== 1'b1 || wrp[1] !== 1'b1) begin
          errors++;
          $display("FAIL wrap_continue busy=%b wrapped=%b want 1 1", busy[1], wrp[1]);
        end
      end
      if (c == 98) begin
        checks++;
        if (fa[1] !== 4'd0 || ic[1] !== 8'd16) begin
          errors++;
          $display("FAIL instr17_addr addr=%0d count=%0d want 0 16", fa[1], ic[1]);
        end
      end
      tick();
    end
    checks++;
    if (en_count != 3) begin
      errors++;
      $display("FAIL counter_en_duty got=%0d want=3", en_count);
    end
  endtask

  task automatic test_halt();
    int late_en;
    late_en = 0;
    do_reset();
    Halt = 1'b1;
    Run  = 1'b1;
    tick();
    Run = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (dv[i] !== ev[i]) begin
          errors++;
          $display("FAIL halt_cycle[%0d] c=%0d got=%h want=%h", i, c, dv[i], ev[i]);
        end
      end
      if (c == 7) begin
        checks++;
        if (busy[0] !== 1'b0 || hlt[0] !== 1'b1 || ic[0] !== 8'd1) begin
          errors++;
          $display("FAIL halt_taken busy=%b halted=%b count=%0d want 0 1 1",
                   busy[0], hlt[0], ic[0]);
        end
      end
      if (c == 8) begin
        checks++;
        if (mar[0] !== 1'b1 || hlt[0] !== 1'b0 || ic[0] !== 8'd0) begin
          errors++;
          $display("FAIL halt_restart mar=%b halted=%b count=%0d want 1 0 0",
                   mar[0], hlt[0], ic[0]);
        end
      end
      if (c >= 14 && ce[0] === 1'b1) late_en++;
      Run = (c == 7);
      tick();
    end
    checks++;
    if (late_en != 0) begin
      errors++;
      $display("FAIL en_after_halt got=%0d want=0", late_en);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    Run = 1'b1;
    tick();
    Run = 1'b0;
    tick();
    checks++;
    if (ce[0] !== 1'b1) begin
      errors++;
      $display("FAIL t1_strobe got=%b want=1", ce[0]);
    end
    #2 Reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (dv[i] !== 22'd0) begin
        errors++;
        $display("FAIL async_reset[%0d] got=%h want=0", i, dv[i]);
      end
    end
    @(negedge Clock);
    Reset = 1'b0;
    Run   = 1'b1;
    tick();
    Run = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (mar[i] !== 1'b1 || dv[i] !== ev[i]) begin
        errors++;
        $display("FAIL restart_t0[%0d] got=%h want=%h", i, dv[i], ev[i]);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (dv[i] !== ev[i]) begin
          errors++;
          $display("FAIL random[%0d] c=%0d got=%h want=%h", i, c, dv[i], ev[i]);
        end
      end
      Run   = ($urandom_range(3) == 0);
      Halt  = ($urandom_range(2) == 0);
      Reset = ($urandom_range(99) == 0);
      tick();
    end
    Reset = 1'b0;
  endtask

  task automatic test_saturate();
    int drops;
    drops = 0;
    do_reset();
    Run = 1'b1;
    tick();
    for (int c = 1; c <= 256 * PERIOD + 12; c++) begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (dv[i] !== ev[i]) begin
          errors++;
          $display("FAIL saturate[%0d] c=%0d got=%h want=%h", i, c, dv[i], ev[i]);
        end
      end
      if (busy[1] !== 1'b1) drops++;
      // Halt only in the first execute slot of the free-running instance
      Halt = m_run[1] && (m_pos[1] == 3) && ($urandom_range(1) == 1);
      tick();
    end
    Run  = 1'b0;
    Halt = 1'b0;
    checks++;
    if (ic[1] !== 8'd255 || drops != 0) begin
      errors++;
      $display("FAIL saturate_end count=%0d busy_drops=%0d want 255 0", ic[1], drops);
    end
  endtask

  initial begin
    tick();
    tick();
    test_reset();
    test_run_and_wrap();
    test_halt();
    test_reset_mid();
    test_random();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_step_sequencer.md
# fetch_step_sequencer

Control sequencer that sits directly upstream of the 4-bit program counter: it generates the counter's `En` strobe and the per-instruction fetch/execute timing slots for the mini 8-bit CPU. Each instruction runs T0 (address to MAR), T1 (counter increment), T2 (instruction register load), then a fixed number of execute slots. The sequencer watches the counter's `blow_up` wrap flag and a decoded `Halt` to decide whether to continue or stop.

## Interface
- `EXEC_CYCLES`, default 3: number of execute slots per instruction, legal range 1..7.
- `WRAP_STOP`, default 1: 1 = return to IDLE after the instruction during which the counter wrapped; 0 = keep running, flag only.
- `Clock` in 1: single system clock, rising edge.
- `Reset` in 1: asynchronous, active-high.
- `Run` in 1: start request, sampled only in IDLE.
- `Halt` in 1: decoded HLT, sampled only in the last execute slot.
- `Counter_Out` in 4: program counter value, pass-through for debug and capture.
- `blow_up` in 1: counter wrap flag (15→0), sampled in T2.
- `Counter_En` out 1: drives the counter `En`, high only in T1.
- `Mar_Load` out 1: high only in T0.
- `Ir_Load` out 1: high only in T2.
- `Exec_En` out 1: high in every execute slot.
- `Exec_Step` out 3: execute slot index 0..EXEC_CYCLES-1, 0 outside EXEC.
- `Busy` out 1: high in any state except IDLE.
- `Halted` out 1: sticky, set when Halt is taken.
- `Wrapped` out 1: sticky, set when a wrap is seen.
- `Fetch_Addr` out 4: Counter_Out captured in T0.
- `Instr_Count` out 8: instructions completed, saturating at 255.

## Operation
- States: IDLE, T0, T1, T2, EXEC. Outputs are Moore-decoded from the registered state and registered counters.
- IDLE: if Run=1, go to T0 and clear Halted, Wrapped and Instr_Count. Otherwise stay.
- T0 → T1: Mar_Load=1; Fetch_Addr <= Counter_Out.
- T1 → T2: Counter_En=1 for exactly one cycle.
- T2 → EXEC: Ir_Load=1. If blow_up=1, set Wrapped and set an internal stop_pending.
- EXEC: Exec_Step counts 0..EXEC_CYCLES-1. At the last slot:
  - Instr_Count += 1, saturating.
  - If Halt=1: set Halted and go to IDLE.
  - Else if WRAP_STOP=1 and stop_pending: go to IDLE.
  - Else go to T0.
- Halt is ignored in all other slots. Run is ignored when not in IDLE.
- Halt and wrap in the same instruction: both flags set, one transition to IDLE.
- Reset, asynchronous at any time: state=IDLE; every output 0; Fetch_Addr=0; Instr_Count=0; Halted=0; Wrapped=0; stop_pending=0. Applies mid-instruction too, with no partial strobe after the assertion edge.

## Timing
- Run sampled high at edge N: T0 occupies cycle N+1, T1 N+2, T2 N+3, EXEC N+4 .. N+3+EXEC_CYCLES.
- Instruction period is 3+EXEC_CYCLES cycles; 6 at the default.
- The counter advances on the edge ending T1, so Counter_Out is +1 during T2.
- Counter_En duty: exactly one high cycle per instruction. Never high in IDLE, T0, T2 or EXEC.
- Return to IDLE: Busy falls on the edge after the last EXEC slot. Instr_Count is already updated on that edge.
- Run high in the first IDLE cycle after a halt restarts immediately, with no dead cycle required.

## Test plan
- Reset then Run pulse, Halt=0, EXEC_CYCLES=3, counter starting at 0: Counter_En high on cycles 2, 8, 14 after the Run edge; Fetch_Addr 0, 1, 2; Instr_Count increments every 6 cycles.
- Halt=1 held for whole run: first instruction completes. Halted=1, Busy=0, Instr_Count=1 on the edge after its last EXEC slot; no further Counter_En.
- WRAP_STOP=1, run 16 instructions from counter 0: blow_up seen in the 16th T2; Wrapped=1; IDLE after instruction 16; Instr_Count=16; Fetch_Addr=15.
- WRAP_STOP=0, same stimulus: Wrapped=1 but sequencing continues; instruction 17 has Fetch_Addr=0.
- Reset asserted during T1: Counter_En drops immediately (asynchronously); all outputs 0; a following Run restarts at T0.
- Run held high continuously plus Halt pulsed only in a non-final EXEC slot: Halt ignored; Run ignored while Busy; Instr_Count saturates at 255 after 255+ instructions.
